// File: rtl/cachepkg.sv
// Shared cache-hierarchy types: request operation, handshake flags and
// the backing-store responder's state encoding.
package cachepkg;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } operation_t;

    typedef logic valid_t;
    typedef logic bool_t;

    typedef logic [1:0] mem_state_t;

    localparam mem_state_t IDLE    = 2'd0;
    localparam mem_state_t WAIT    = 2'd1;
    localparam mem_state_t RESPOND = 2'd2;
    localparam mem_state_t DRAIN   = 2'd3;

    // Latency counter width; never below one bit.
    function automatic int cnt_width(input int lat);
        return (lat > 1) ? $clog2(lat) : 1;
    endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous line RAM, written and read through one address.
// No reset, so contents persist and block-RAM inference stays possible.
module mem_array #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 512
) (
    input  logic                     clock,
    input  logic                     en,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Read-first port: registered read, optional write at the same address.
    always_ff @(posedge clock) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/line_mem_responder.sv
// Fixed-latency line backing store terminating the last cache level.
// Optional out-of-range detection and err port: define MEM_RESP_RANGE_EN.
module line_mem_responder
    import cachepkg::*;
#(
    parameter int ADDRBITS = 32,
    parameter int LINEBITS = 512,
    parameter int DEPTH    = 1024,
    parameter int LATENCY  = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                request,
    input  operation_t          operation,
    input  logic [ADDRBITS-1:0] addr,
    input  logic [LINEBITS-1:0] wdata,
    output logic [LINEBITS-1:0] rdata,
    output logic                valid,
    output logic                busy,
    output logic                evict,
    output logic                invalidate
`ifdef MEM_RESP_RANGE_EN
    ,
    output logic                err
`endif
);

    localparam int OFFBITS = $clog2(LINEBITS / 8);
    localparam int IDXBITS = $clog2(DEPTH);
    localparam int CNTW    = cnt_width(LATENCY);

    localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(LATENCY - 1);

    mem_state_t          state;
    mem_state_t          nxt;
    logic [CNTW-1:0]     cnt;
    operation_t          op_q;
    logic [IDXBITS-1:0]  idx_q;
    logic [LINEBITS-1:0] wdata_q;
    logic [IDXBITS-1:0]  in_idx;
    logic [IDXBITS-1:0]  ram_addr;
    logic [LINEBITS-1:0] ram_q;
    logic                ram_en;
    logic                ram_we;
    bool_t               accept;
    bool_t               commit;
    bool_t               in_range;

    assign in_idx = IDXBITS'(addr >> OFFBITS);
    assign accept = (state == IDLE) && request;
    assign commit = (state == WAIT) && (cnt == '0);

    assign evict      = 1'b0;
    assign invalidate = 1'b0;

`ifdef MEM_RESP_RANGE_EN
    logic oor_q;

    assign in_range = !oor_q;

    // Capture whether any address bit above the index field was set.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            oor_q <= 1'b0;
            err   <= 1'b0;
        end else begin
            if (accept) begin
                oor_q <= |(addr >> (OFFBITS + IDXBITS));
            end
            err <= commit && oor_q;
        end
    end
`else
    assign in_range = 1'b1;
`endif

    // Read at acceptance, write on the edge that enters RESPOND.
    assign ram_we   = commit && (op_q == WRITE) && in_range;
    assign ram_en   = accept || ram_we;
    assign ram_addr = accept ? in_idx : idx_q;

    mem_array #(
        .DEPTH (DEPTH),
        .WIDTH (LINEBITS)
    ) u_mem (
        .clock (clock),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (wdata_q),
        .rdata (ram_q)
    );

    // Next-state decode; DRAIN holds until the requester lets go.
    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (request) nxt = WAIT;
            WAIT:    if (cnt == '0) nxt = RESPOND;
            RESPOND: nxt = DRAIN;
            DRAIN:   if (!request) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // State, latched request, latency counter and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            op_q    <= READ;
            idx_q   <= '0;
            wdata_q <= '0;
            valid   <= 1'b0;
            busy    <= 1'b0;
            rdata   <= '0;
        end else begin
            state <= nxt;
            valid <= (nxt == RESPOND);
            busy  <= (nxt != IDLE);
            if (commit && (op_q == READ) && in_range) begin
                rdata <= ram_q;
            end else begin
                rdata <= '0;
            end
            if (accept) begin
                op_q    <= operation;
                idx_q   <= in_idx;
                wdata_q <= wdata;
                cnt     <= CNT_LOAD;
            end else if ((state == WAIT) && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_line_mem_responder.sv
// Directed and randomized checks of line_mem_responder against a line model.
// Range checks run when MEM_RESP_RANGE_EN is defined.
module tb_line_mem_responder;
    import cachepkg::*;

    localparam int LAT = 4;
    localparam int LB  = 512;
    localparam int DEP = 1024;

    logic          clock = 1'b0;
    logic          reset;
    logic          request;
    operation_t    operation;
    logic [31:0]   addr;
    logic [LB-1:0] wdata;
    logic [LB-1:0] rdata;
    logic          valid;
    logic          busy;
    logic          evict;
    logic          invalidate;
`ifdef MEM_RESP_RANGE_EN
    logic          err;
`endif

    int compares = 0;
    int fails    = 0;

    logic [LB-1:0] model [int];

    line_mem_responder #(
        .ADDRBITS (32),
        .LINEBITS (LB),
        .DEPTH    (DEP),
        .LATENCY  (LAT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .request    (request),
        .operation  (operation),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .valid      (valid),
        .busy       (busy),
        .evict      (evict),
        .invalidate (invalidate)
`ifdef MEM_RESP_RANGE_EN
        ,
        .err        (err)
`endif
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [LB-1:0] obs,
                         input logic [LB-1:0] exp);
        compares++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LB-1:0] rand_line();
        logic [LB-1:0] r;
        for (int i = 0; i < LB / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'((a / 32'd64) % DEP);
    endfunction

    function automatic logic cur_err();
`ifdef MEM_RESP_RANGE_EN
        return err;
`else
        return 1'b0;
`endif
    endfunction

    // One full transaction; hold = cycles request stays high after valid.
    task automatic txn(input bit wr, input logic [31:0] a,
                       input logic [LB-1:0] d, input int hold,
                       output logic [LB-1:0] rd, output logic e);
        int n;
        bit got;
        @(negedge clock);
        check("busy_before_req", busy, 1'b0);
        request   = 1'b1;
        operation = wr ? WRITE : READ;
        addr      = a;
        wdata     = d;
        n   = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clock);
            n++;
            if (n == 1) check("busy_after_accept", busy, 1'b1);
            addr      = $urandom;
            wdata     = rand_line();
            operation = wr ? READ : WRITE;
            got       = valid;
        end
        check("latency", n, LAT + 1);
        rd = rdata;
        e  = cur_err();
        for (int h = 0; h < hold; h++) begin
            @(negedge clock);
            check("hold_single_valid", {valid, busy}, 2'b01);
        end
        request = 1'b0;
        if (hold == 0) begin
            @(negedge clock);
            check("drain_busy", {valid, busy}, 2'b01);
        end
        @(negedge clock);
        check("back_to_idle", {valid, busy}, 2'b00);
    endtask

    initial begin
        logic [LB-1:0] line;
        logic [LB-1:0] pre;
        logic [LB-1:0] d;
        logic [LB-1:0] rd;
        logic [31:0]   a;
        logic          e;
        bit            wr;
        int            li;

        reset     = 1'b1;
        request   = 1'b0;
        operation = READ;
        addr      = '0;
        wdata     = '0;
        #2 reset = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            check("reset_rdata", rdata, '0);
            check("reset_flags", {valid, busy, evict, invalidate, cur_err()}, '0);
        end

        line = {16{32'hDEADBEEF}};
        txn(1'b1, 32'h40, line, 0, rd, e);
        model[idx_of(32'h40)] = line;
        check("write_rdata_zero", rd, '0);
        txn(1'b0, 32'h40, '0, 0, rd, e);
        check("read_back_40", rd, model[idx_of(32'h40)]);
        txn(1'b0, 32'h7F, '0, 0, rd, e);
        check("read_offset_7f", rd, model[idx_of(32'h7F)]);
        txn(1'b0, 32'h40, '0, 3, rd, e);
        check("read_hold_3", rd, model[idx_of(32'h40)]);

        pre = rand_line();
        txn(1'b1, 32'h80, pre, 0, rd, e);
        model[idx_of(32'h80)] = pre;
        @(negedge clock);
        request   = 1'b1;
        operation = WRITE;
        addr      = 32'h80;
        wdata     = ~pre;
        @(negedge clock);
        @(negedge clock);
        check("abort_busy_before", busy, 1'b1);
        reset = 1'b0;
        #1;
        check("abort_flags", {valid, busy, cur_err()}, '0);
        check("abort_rdata", rdata, '0);
        request = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        txn(1'b0, 32'h80, '0, 0, rd, e);
        check("abort_no_commit", rd, model[idx_of(32'h80)]);

        d = rand_line();
        txn(1'b1, 32'h0, d, 0, rd, e);
        model[0] = d;
`ifdef MEM_RESP_RANGE_EN
        txn(1'b1, 32'h0001_0000, rand_line(), 0, rd, e);
        check("oor_write_err", e, 1'b1);
        txn(1'b0, 32'h0, '0, 0, rd, e);
        check("oor_write_dropped", rd, model[0]);
        check("inrange_err", e, 1'b0);
        txn(1'b0, 32'h0002_0040, '0, 1, rd, e);
        check("oor_read_err", e, 1'b1);
        check("oor_read_zero", rd, '0);
`else
        d = rand_line();
        txn(1'b1, 32'h0001_0000, d, 0, rd, e);
        model[idx_of(32'h0001_0000)] = d;
        txn(1'b0, 32'h0, '0, 0, rd, e);
        check("alias_upper_bits", rd, model[0]);
`endif

        for (int t = 0; t < 40; t++) begin
            li = 8 + int'($urandom_range(0, 7));
            a  = 32'(li * 64) + 32'($urandom_range(0, 63));
`ifndef MEM_RESP_RANGE_EN
            a = a | (32'($urandom_range(0, 255)) << 16);
`endif
            wr = !model.exists(li) || ($urandom_range(0, 1) == 1);
            d  = rand_line();
            txn(wr, a, d, int'($urandom_range(0, 2)), rd, e);
            if (wr) begin
                model[li] = d;
                check("rand_write_rdata", rd, '0);
            end else begin
                check("rand_read", rd, model[li]);
            end
            check("rand_err", e, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end

endmodule
